// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multi-cycle controller and the RV32I datapath
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, state_dbg
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM with memory-ready stalls and trap on unsupported opcodes
module multicycle_controller #(
    parameter bit EN_IMM   = 1'b1,
    parameter bit EN_JAL   = 1'b1,
    parameter bit EN_BNE   = 1'b1,
    parameter bit WAIT_MEM = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t     state, next;
    logic       rdy, taken, pc_w, ir_w, reg_w, mrd, mwr, adr;
    logic [1:0] rs, a, b, aop;

    assign rdy   = WAIT_MEM ? bus.mem_ready : 1'b1;
    assign taken = (bus.funct3 == 3'b000 && bus.zero) || (EN_BNE && bus.funct3 == 3'b001 && !bus.zero);

    // state register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next;
    end

    // next-state and control decode
    always_comb begin
        next  = state;
        pc_w  = 1'b0;
        ir_w  = 1'b0;
        reg_w = 1'b0;
        mrd   = 1'b0;
        mwr   = 1'b0;
        adr   = 1'b0;
        rs    = 2'b00;
        a     = 2'b00;
        b     = 2'b00;
        aop   = 2'b00;
        case (state)
            FETCH: begin
                mrd  = 1'b1;
                b    = 2'b10;
                rs   = 2'b10;
                pc_w = rdy;
                ir_w = rdy;
                next = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                a = 2'b01;
                b = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: next = MEMADR;
                    7'b0110011:             next = EXECR;
                    7'b0010011:             next = EN_IMM ? EXECI : TRAP;
                    7'b1100011:             next = (bus.funct3 == 3'b000 || (EN_BNE && bus.funct3 == 3'b001)) ? BRANCH : TRAP;
                    7'b1101111:             next = EN_JAL ? JAL : TRAP;
                    default:                next = TRAP;
                endcase
            end
            MEMADR: begin
                a    = 2'b10;
                b    = 2'b01;
                next = (bus.op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr  = 1'b1;
                mrd  = 1'b1;
                next = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                rs    = 2'b01;
                reg_w = 1'b1;
                next  = FETCH;
            end
            MEMWRITE: begin
                adr  = 1'b1;
                mwr  = 1'b1;
                next = rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                a    = 2'b10;
                aop  = 2'b10;
                next = ALUWB;
            end
            EXECI: begin
                a    = 2'b10;
                b    = 2'b01;
                aop  = 2'b10;
                next = ALUWB;
            end
            ALUWB: begin
                reg_w = 1'b1;
                next  = FETCH;
            end
            BRANCH: begin
                a    = 2'b10;
                aop  = 2'b01;
                pc_w = taken;
                next = FETCH;
            end
            JAL: begin
                a    = 2'b01;
                b    = 2'b10;
                pc_w = 1'b1;
                next = ALUWB;
            end
            TRAP:    next = TRAP;
            default: next = TRAP;
        endcase
    end

    assign bus.pc_write   = pc_w & rst_n;
    assign bus.ir_write   = ir_w & rst_n;
    assign bus.reg_write  = reg_w & rst_n;
    assign bus.mem_read   = mrd & rst_n;
    assign bus.mem_write  = mwr & rst_n;
    assign bus.adr_src    = adr;
    assign bus.result_src = rs;
    assign bus.alu_src_a  = a;
    assign bus.alu_src_b  = b;
    assign bus.alu_op     = aop;
    assign bus.illegal_op = (state == TRAP);
    assign bus.state_dbg  = state;
    assign bus.imm_src    = (bus.op == 7'b0100011) ? 2'b01 :
                            (bus.op == 7'b1100011) ? 2'b10 :
                            (bus.op == 7'b1101111) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for the multi-cycle controller and two parameter variants
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        string       tag;
        int          d;
        logic [23:0] v;
    } exp_t;
    exp_t q[$];

    multicycle_controller_if i0();
    multicycle_controller_if i1();
    multicycle_controller_if i2();

    assign i0.op = op; assign i0.funct3 = funct3; assign i0.zero = zero; assign i0.mem_ready = mem_ready;
    assign i1.op = op; assign i1.funct3 = funct3; assign i1.zero = zero; assign i1.mem_ready = mem_ready;
    assign i2.op = op; assign i2.funct3 = funct3; assign i2.zero = zero; assign i2.mem_ready = mem_ready;

    multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(i0));
    multicycle_controller #(.EN_BNE(1'b0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(i1));
    multicycle_controller #(.WAIT_MEM(1'b0)) dut_nw (.clk(clk), .rst_n(rst_n), .bus(i2));

    always #5 clk = ~clk;

    // expected output vector for a state: {a,b,alu_op,00,state,pcw,irw,rw,mr,mw,ill,rs,imm,adr,0}
    function automatic logic [23:0] ex(input int st, input logic pcw, input logic irw);
        logic [1:0] a, b, aop, rs, imm;
        logic rw, mr, mw, ill, adr;
        {a, b, aop, rs, rw, mr, mw, ill, adr} = '0;
        case (st)
            0:  begin b = 2; rs = 2; mr = 1; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin adr = 1; mr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2; aop = 2; end
            7:  begin a = 2; b = 1; aop = 2; end
            8:  rw = 1;
            9:  begin a = 2; aop = 1; end
            10: begin a = 1; b = 2; end
            default: ill = 1;
        endcase
        imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 : (op == 7'b1101111) ? 2'd3 : 2'd0;
        if (!rst_n) {pcw, irw, rw, mr, mw} = '0;
        return {a, b, aop, 2'b00, st[3:0], pcw, irw, rw, mr, mw, ill, rs, imm, adr, 1'b0};
    endfunction

    function automatic logic [23:0] obs(input int d);
        case (d)
            0: return {i0.alu_src_a, i0.alu_src_b, i0.alu_op, 2'b00, i0.state_dbg, i0.pc_write, i0.ir_write,
                       i0.reg_write, i0.mem_read, i0.mem_write, i0.illegal_op, i0.result_src, i0.imm_src, i0.adr_src, 1'b0};
            1: return {i1.alu_src_a, i1.alu_src_b, i1.alu_op, 2'b00, i1.state_dbg, i1.pc_write, i1.ir_write,
                       i1.reg_write, i1.mem_read, i1.mem_write, i1.illegal_op, i1.result_src, i1.imm_src, i1.adr_src, 1'b0};
            default: return {i2.alu_src_a, i2.alu_src_b, i2.alu_op, 2'b00, i2.state_dbg, i2.pc_write, i2.ir_write,
                       i2.reg_write, i2.mem_read, i2.mem_write, i2.illegal_op, i2.result_src, i2.imm_src, i2.adr_src, 1'b0};
        endcase
    endfunction

    // push the expectation for the inputs just driven, then pop and compare once outputs settle
    task automatic cyc(input int d, input int st, input logic pcw, input logic irw, input string tag);
        exp_t e;
        logic [23:0] o;
        q.push_back('{tag, d, ex(st, pcw, irw)});
        #1;
        e = q.pop_front();
        o = obs(e.d);
        tests++;
        assert (o === e.v) else begin
            fails++;
            $error("FAIL %s dut%0d: observed %h expected %h", e.tag, e.d, o, e.v);
        end
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, 0, "reset");
        rst_n = 1'b1;
        op = 7'b0110011;
        cyc(0, 0, 1, 1, "add_fetch");
        cyc(0, 1, 0, 0, "add_decode");
        cyc(0, 6, 0, 0, "add_execr");
        cyc(0, 8, 0, 0, "add_aluwb");
        op = 7'b0000011;
        cyc(0, 0, 1, 1, "lw_fetch");
        cyc(0, 1, 0, 0, "lw_decode");
        cyc(0, 2, 0, 0, "lw_memadr");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 3, 0, 0, "lw_stall");
        mem_ready = 1'b1;
        cyc(0, 3, 0, 0, "lw_memread");
        cyc(0, 4, 0, 0, "lw_memwb");
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        cyc(0, 0, 1, 1, "beq_fetch");
        cyc(0, 1, 0, 0, "beq_decode");
        cyc(0, 9, 1, 0, "beq_taken");
        zero = 1'b0;
        cyc(0, 0, 1, 1, "beq2_fetch");
        cyc(0, 1, 0, 0, "beq2_decode");
        cyc(0, 9, 0, 0, "beq_not_taken");
        funct3 = 3'b001;
        cyc(0, 0, 1, 1, "bne_fetch");
        cyc(0, 1, 0, 0, "bne_decode");
        cyc(0, 9, 1, 0, "bne_taken");
        zero = 1'b1;
        cyc(0, 0, 1, 1, "bne2_fetch");
        cyc(0, 1, 0, 0, "bne2_decode");
        cyc(0, 9, 0, 0, "bne_not_taken");
        op = 7'b0100011; funct3 = 3'b010;
        cyc(0, 0, 1, 1, "sw_fetch");
        cyc(0, 1, 0, 0, "sw_decode");
        cyc(0, 2, 0, 0, "sw_memadr");
        mem_ready = 1'b0;
        cyc(0, 5, 0, 0, "sw_write1");
        mem_ready = 1'b1;
        cyc(0, 5, 0, 0, "sw_write2");
        op = 7'b1101111;
        cyc(0, 0, 1, 1, "jal_fetch");
        cyc(0, 1, 0, 0, "jal_decode");
        cyc(0, 10, 1, 0, "jal_jal");
        cyc(0, 8, 0, 0, "jal_aluwb");
        op = 7'b0010011; funct3 = 3'b000;
        cyc(0, 0, 1, 1, "addi_fetch");
        cyc(0, 1, 0, 0, "addi_decode");
        cyc(0, 7, 0, 0, "addi_execi");
        cyc(0, 8, 0, 0, "addi_aluwb");
        op = 7'b1111111;
        mem_ready = 1'b0;
        cyc(0, 0, 0, 0, "bad_fetch_wait");
        mem_ready = 1'b1;
        cyc(0, 0, 1, 1, "bad_fetch");
        cyc(0, 1, 0, 0, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(0, 11, 0, 0, "trap_hold");
        #2 rst_n = 1'b0;
        cyc(0, 0, 0, 0, "async_reset");
        rst_n = 1'b1;
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        cyc(1, 0, 1, 1, "nb_beq_fetch");
        cyc(1, 1, 0, 0, "nb_beq_decode");
        cyc(1, 9, 1, 0, "nb_beq_taken");
        funct3 = 3'b001; zero = 1'b0;
        cyc(1, 0, 1, 1, "nb_bne_fetch");
        cyc(1, 1, 0, 0, "nb_bne_decode");
        cyc(1, 11, 0, 0, "nb_bne_trap");
        rst_n = 1'b0;
        cyc(2, 0, 0, 0, "nw_reset");
        rst_n = 1'b1;
        mem_ready = 1'b0;
        op = 7'b0000011;
        cyc(2, 0, 1, 1, "nw_lw_fetch");
        cyc(2, 1, 0, 0, "nw_lw_decode");
        cyc(2, 2, 0, 0, "nw_lw_memadr");
        cyc(2, 3, 0, 0, "nw_lw_memread");
        cyc(2, 4, 0, 0, "nw_lw_memwb");
        op = 7'b0100011;
        cyc(2, 0, 1, 1, "nw_sw_fetch");
        cyc(2, 1, 0, 0, "nw_sw_decode");
        cyc(2, 2, 0, 0, "nw_sw_memadr");
        cyc(2, 5, 0, 0, "nw_sw_memwrite");
        cyc(2, 0, 1, 1, "nw_next_fetch");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control unit for the RV32I core, the successor to the single-cycle opcode decoder.
- A state machine steps each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles.
- A ready handshake stalls the machine for variable-latency unified memory.
- Parameters enable or disable optional instruction classes; unsupported opcodes trap.

Parameters:
- EN_IMM, 1: enable I-type ALU ops (op 0010011).
- EN_JAL, 1: enable JAL (op 1101111).
- EN_BNE, 1: enable BNE (funct3 001) alongside BEQ.
- WAIT_MEM, 1: 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode from the instruction register.
- funct3  in  3  instruction funct3.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register and old-PC load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
- alu_op  out  2  ALU op class to the ALU decoder: 00 add, 01 subtract, 10 funct-decoded.
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal_op  out  1  sticky trap flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset is asynchronous on rst_n low.
  - state <= FETCH.
  - While rst_n is low, the strobes pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0.
  - illegal_op = 0.
  - All select outputs take their FETCH values.
- Reset mid-instruction aborts it; no strobe is asserted after rst_n falls.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5.
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11.
  - Encodings 12-15 go to TRAP.
- Outputs are Moore, except pc_write, ir_write and the mem_ready-gated transitions.
- Any strobe not listed for a state is 0.
- FETCH:
  - Outputs: adr_src=0, mem_read=1, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_write = mem_ready.
  - Advance to DECODE only when mem_ready; otherwise hold.
- DECODE:
  - Outputs: a=01, b=01, alu_op=00 (branch target precomputed).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 with EN_IMM -> EXECI.
    - 1100011 with funct3 000, or funct3 001 with EN_BNE -> BRANCH.
    - 1101111 with EN_JAL -> JAL.
    - Anything else -> TRAP.
- MEMADR: a=10, b=01, alu_op=00. Next state: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD:
  - Outputs: adr_src=1, mem_read=1, result_src=00.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE:
  - Outputs: adr_src=1, mem_write=1, result_src=00.
  - mem_write is held high until mem_ready, then go to FETCH.
- EXECR: a=10, b=00, alu_op=10. Next state ALUWB.
- EXECI: a=10, b=01, alu_op=10. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH:
  - Outputs: a=10, b=00, alu_op=01, result_src=00.
  - pc_write = taken, where taken = (funct3==000 & zero) | (EN_BNE & funct3==001 & !zero).
  - Next state FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Next state ALUWB (rd <= PC+4).
- TRAP:
  - All strobes 0; illegal_op=1.
  - The state is absorbing until reset.
- imm_src is combinational from op in every state:
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - Otherwise 00.
- mem_read and mem_write are never both 1.
- With WAIT_MEM=0, every memory state completes in one cycle.
- Instruction latency with mem_ready always 1:
  - 5 cycles: lw.
  - 4 cycles: sw, R-type, I-type, jal.
  - 3 cycles: beq/bne.

Test Plan:
- Reset, then add (op 0110011) with mem_ready=1 -> states 0,1,6,8,0. reg_write=1 only in cycle 4. pc_write=1 only in cycle 1.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> state_dbg stays 3 for 3 cycles with mem_read=1, then 4 with reg_write=1 and result_src=01.
- beq (funct3 000) with zero=1 -> pc_write=1 in BRANCH. Repeat with zero=0 -> pc_write=0. bne with zero=0 -> pc_write=1. Rebuild with EN_BNE=0: bne -> TRAP, illegal_op=1.
- sw with mem_ready asserted on the 2nd MEMWRITE cycle -> mem_write high for exactly 2 cycles, imm_src=01, reg_write never 1.
- Opcode 1111111 -> DECODE then TRAP. illegal_op stays 1 for 20 cycles. Assert rst_n=0 asynchronously mid-cycle -> illegal_op=0 and state_dbg=0 immediately.
- jal with EN_JAL=1 -> states 1,10,8. pc_write=1 in state 10. imm_src=11. With WAIT_MEM=0, FETCH lasts 1 cycle even with mem_ready=0.
